// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the SDMips program-counter sequencer:
//   - estado_t   : FSM state encoding (00 INICIO, 01 EXEC, 10 ESPERA, 11 PARADO)
//   - PC_RESET_PADRAO / VETOR_EXC_PADRAO : default reset PC and exception vector
//   - desloc_desvio() : sign-extends a 16-bit word offset and scales it to bytes
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    EST_INICIO = 2'b00,
    EST_EXEC   = 2'b01,
    EST_ESPERA = 2'b10,
    EST_PARADO = 2'b11
  } estado_t;

  localparam logic [31:0] PC_RESET_PADRAO  = 32'h0000_0000;
  localparam logic [31:0] VETOR_EXC_PADRAO = 32'h0000_0080;

  // Branch immediates are in words: sign-extend to 30 bits, then append 2'b00.
  function automatic logic [31:0] desloc_desvio(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/somador_pc.sv
// ---------------------------------------------------------------------------
// somador_pc
// Sequential-address adder: pc_mais4 = pc + 4 (modulo 2^32, no carry out).
// Ports:
//   pc       in  32  current fetch address
//   pc_mais4 out 32  pc + 4, combinational
// ---------------------------------------------------------------------------
module somador_pc (
  input  logic [31:0] pc,
  output logic [31:0] pc_mais4
);

  assign pc_mais4 = pc + 32'd4;

endmodule

// File: rtl/pc_sequenciador.sv
// ---------------------------------------------------------------------------
// pc_sequenciador
// Owns the SDMips PC register and selects its next value every clock among
// exception vector, stall/halt hold, jump-register, jump, conditional branch
// and sequential PC+4.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               hold PC this cycle, enter ESPERA
//   parar               halt request, enter PARADO
//   excecao             exception: PC <= VETOR_EXC (highest priority)
//   desvio/offset_desvio  conditional branch taken / signed word offset
//   salto/alvo_salto    jump / 26-bit target field
//   salto_reg/reg_alvo  jump register / 32-bit target
//   pc, pc_mais4        current fetch address and pc+4 (combinational)
//   pc_valido           pc is a valid fetch address (EXEC or ESPERA)
//   estado              FSM state
//   erro_alinhamento    one-cycle pulse after a misaligned jr target
// ---------------------------------------------------------------------------
module pc_sequenciador
  import pc_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_PADRAO,
  parameter logic [31:0] VETOR_EXC = VETOR_EXC_PADRAO
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        parar,
  input  logic        excecao,
  input  logic        desvio,
  input  logic [15:0] offset_desvio,
  input  logic        salto,
  input  logic [25:0] alvo_salto,
  input  logic        salto_reg,
  input  logic [31:0] reg_alvo,
  output logic [31:0] pc,
  output logic [31:0] pc_mais4,
  output logic        pc_valido,
  output logic [1:0]  estado,
  output logic        erro_alinhamento
);

  logic [31:0] pc_q, pc_d;
  estado_t     estado_q, estado_d;
  logic        erro_q, erro_d;
  logic [31:0] alvo_desvio;

  somador_pc u_somador_pc (
    .pc       (pc_q),
    .pc_mais4 (pc_mais4)
  );

  assign alvo_desvio = pc_mais4 + desloc_desvio(offset_desvio);

  always_comb begin
    pc_d     = pc_q;
    estado_d = estado_q;
    erro_d   = 1'b0;
    case (estado_q)
      EST_INICIO: estado_d = EST_EXEC;
      EST_EXEC, EST_ESPERA: begin
        if (excecao) begin
          pc_d     = VETOR_EXC;
          estado_d = EST_EXEC;
        end else if (stall) begin
          // Redirect inputs are held by their source until stall drops,
          // so they are simply not looked at here.
          estado_d = EST_ESPERA;
        end else if (parar) begin
          estado_d = EST_PARADO;
        end else begin
          estado_d = EST_EXEC;
          if (salto_reg) begin
            if (reg_alvo[1:0] == 2'b00) begin
              pc_d = reg_alvo;
            end else begin
              pc_d   = VETOR_EXC;
              erro_d = 1'b1;
            end
          end else if (salto) begin
            pc_d = {pc_mais4[31:28], alvo_salto, 2'b00};
          end else if (desvio) begin
            pc_d = alvo_desvio;
          end else begin
            pc_d = pc_mais4;
          end
        end
      end
      EST_PARADO: begin
        // Only an exception (or reset) wakes the core from halt.
        if (excecao) begin
          pc_d     = VETOR_EXC;
          estado_d = EST_EXEC;
        end
      end
      default: estado_d = EST_INICIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RESET;
      estado_q <= EST_INICIO;
      erro_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      estado_q <= estado_d;
      erro_q   <= erro_d;
    end
  end

  assign pc               = pc_q;
  assign estado           = estado_q;
  assign pc_valido        = (estado_q == EST_EXEC) || (estado_q == EST_ESPERA);
  assign erro_alinhamento = erro_q;

endmodule

// File: tb/tb_pc_sequenciador.sv
// ---------------------------------------------------------------------------
// tb_pc_sequenciador
// Scoreboard bench: the stimulus process advances a behavioural PC model and
// queues the expected outputs for each cycle; a monitor pops and compares on
// every falling edge (or on demand for the asynchronous-reset check).
// ---------------------------------------------------------------------------
module tb_pc_sequenciador;

  localparam int S_INICIO = 0;
  localparam int S_EXEC   = 1;
  localparam int S_ESPERA = 2;
  localparam int S_PARADO = 3;
  localparam logic [31:0] VETOR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, parar = 1'b0, excecao = 1'b0;
  logic        desvio = 1'b0, salto = 1'b0, salto_reg = 1'b0;
  logic [15:0] offset_desvio = '0;
  logic [25:0] alvo_salto = '0;
  logic [31:0] reg_alvo = '0;
  logic [31:0] pc, pc_mais4;
  logic        pc_valido, erro_alinhamento;
  logic [1:0]  estado;

  always #5 clk = ~clk;

  pc_sequenciador dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .parar            (parar),
    .excecao          (excecao),
    .desvio           (desvio),
    .offset_desvio    (offset_desvio),
    .salto            (salto),
    .alvo_salto       (alvo_salto),
    .salto_reg        (salto_reg),
    .reg_alvo         (reg_alvo),
    .pc               (pc),
    .pc_mais4         (pc_mais4),
    .pc_valido        (pc_valido),
    .estado           (estado),
    .erro_alinhamento (erro_alinhamento)
  );

  typedef struct {
    logic        exc, stl, par, sr;
    logic [31:0] ra;
    logic        sj;
    logic [25:0] alvo;
    logic        br;
    logic [15:0] off;
  } estimulo_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  est;
    logic        valido;
    logic        err;
    string       nome;
  } esperado_t;

  esperado_t fila[$];
  int n_assert = 0;
  int n_fail   = 0;
  event amostra;

  // Behavioural model state
  logic [31:0] m_pc;
  int          m_st;
  logic        m_err;

  function automatic estimulo_t est(input logic exc, input logic stl, input logic par,
                                    input logic sr, input logic [31:0] ra, input logic sj,
                                    input logic [25:0] alvo, input logic br,
                                    input logic [15:0] off);
    estimulo_t s;
    s.exc = exc; s.stl = stl; s.par = par; s.sr = sr; s.ra = ra;
    s.sj = sj; s.alvo = alvo; s.br = br; s.off = off;
    return s;
  endfunction

  function automatic void modelo_reset();
    m_pc  = 32'h0;
    m_st  = S_INICIO;
    m_err = 1'b0;
  endfunction

  // Next-PC rules expressed arithmetically on the model's integers.
  function automatic void modelo_passo(input estimulo_t s);
    logic [31:0] seq;
    seq   = m_pc + 32'd4;
    m_err = 1'b0;
    if (m_st == S_INICIO) begin
      m_st = S_EXEC;
    end else if (m_st == S_PARADO) begin
      if (s.exc) begin m_pc = VETOR; m_st = S_EXEC; end
    end else if (s.exc) begin
      m_pc = VETOR; m_st = S_EXEC;
    end else if (s.stl) begin
      m_st = S_ESPERA;
    end else if (s.par) begin
      m_st = S_PARADO;
    end else begin
      m_st = S_EXEC;
      if (s.sr) begin
        if (s.ra % 4 == 0) m_pc = s.ra;
        else begin m_pc = VETOR; m_err = 1'b1; end
      end else if (s.sj) begin
        m_pc = (seq & 32'hF000_0000) | (32'(s.alvo) * 4);
      end else if (s.br) begin
        m_pc = seq + 32'(int'($signed(s.off)) * 4);
      end else begin
        m_pc = seq;
      end
    end
  endfunction

  function automatic void empilha(input string nome);
    esperado_t e;
    e.pc     = m_pc;
    e.est    = 2'(m_st);
    e.valido = (m_st == S_EXEC) || (m_st == S_ESPERA);
    e.err    = m_err;
    e.nome   = nome;
    fila.push_back(e);
  endfunction

  // Drive one cycle of stimulus (at posedge+1), predict, and queue expectation.
  task automatic passo(input estimulo_t s, input string nome);
    excecao = s.exc; stall = s.stl; parar = s.par; salto_reg = s.sr; reg_alvo = s.ra;
    salto = s.sj; alvo_salto = s.alvo; desvio = s.br; offset_desvio = s.off;
    modelo_passo(s);
    @(posedge clk);
    #1;
    empilha(nome);
  endtask

  task automatic compara(input string nome, input string campo,
                         input logic [31:0] obtido, input logic [31:0] esperado);
    n_assert++;
    if (obtido !== esperado) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nome, campo, obtido, esperado);
    end
  endtask

  // Monitor: one expectation consumed per falling edge or explicit sample event.
  initial begin
    esperado_t e;
    forever begin
      @(negedge clk or amostra);
      if (fila.size() > 0) begin
        e = fila.pop_front();
        compara(e.nome, "pc",               pc,                       e.pc);
        compara(e.nome, "pc_mais4",         pc_mais4,                 e.pc + 32'd4);
        compara(e.nome, "pc_valido",        32'(pc_valido),           32'(e.valido));
        compara(e.nome, "estado",           32'(estado),              32'(e.est));
        compara(e.nome, "erro_alinhamento", 32'(erro_alinhamento),    32'(e.err));
        $display("[%0t] %s pc=%h est=%0d val=%0b err=%0b", $time, e.nome, pc, estado,
                 pc_valido, erro_alinhamento);
      end
    end
  end

  initial begin
    estimulo_t s;
    estimulo_t nada;
    nada = est(0, 0, 0, 0, 32'h0, 0, 26'h0, 0, 16'h0);
    modelo_reset();

    // Reset held 3 cycles, then the INICIO cycle, then free run 0,4,8,12
    repeat (3) @(posedge clk);
    #1;
    empilha("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    empilha("inicio");
    for (int i = 0; i < 4; i++) passo(nada, "seq");

    // Branches both directions
    passo(est(0, 0, 0, 1, 32'h10, 0, 26'h0, 0, 16'h0), "jr_0x10");
    passo(est(0, 0, 0, 0, 32'h0, 0, 26'h0, 1, 16'h0003), "br_fwd");
    passo(est(0, 0, 0, 0, 32'h0, 0, 26'h0, 1, 16'hFFFE), "br_back");

    // Jumps
    passo(est(0, 0, 0, 1, 32'h1000_0040, 0, 26'h0, 0, 16'h0), "jr_setup");
    passo(est(0, 0, 0, 0, 32'h0, 1, 26'h0000100, 0, 16'h0), "j_region");
    passo(est(0, 0, 0, 1, 32'h0000_0200, 0, 26'h0, 0, 16'h0), "jr_align");
    passo(est(0, 0, 0, 1, 32'h0000_0202, 0, 26'h0, 0, 16'h0), "jr_misalign");
    passo(nada, "err_clears");

    // Stall and priority
    passo(est(0, 0, 0, 1, 32'h8, 0, 26'h0, 0, 16'h0), "jr_0x8");
    passo(est(0, 1, 0, 1, 32'h400, 1, 26'h55, 1, 16'h7), "stall1");
    passo(est(0, 1, 0, 1, 32'h400, 1, 26'h55, 1, 16'h7), "stall2");
    passo(est(1, 1, 0, 0, 32'h0, 0, 26'h0, 0, 16'h0), "stall_exc");
    passo(est(0, 0, 0, 0, 32'h0, 1, 26'h40, 1, 16'h5), "j_over_br");

    // Halt: frozen for 5 cycles despite redirects, exception wakes it
    passo(est(0, 0, 0, 1, 32'h30, 0, 26'h0, 0, 16'h0), "jr_0x30");
    passo(est(0, 0, 1, 0, 32'h0, 0, 26'h0, 0, 16'h0), "parar");
    for (int i = 0; i < 5; i++)
      passo(est(0, i[0], 1, 1, 32'h100, 1, 26'h3, 1, 16'h1), "parado");
    passo(est(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 16'h0), "exc_wake");

    // Wrap-around at the top of the address space
    passo(est(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0, 0, 16'h0), "jr_top");
    passo(nada, "wrap");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s.exc  = ($urandom_range(99) < 3);
      s.stl  = ($urandom_range(99) < 15);
      s.par  = ($urandom_range(99) < 2);
      s.sr   = ($urandom_range(99) < 10);
      s.ra   = $urandom;
      if ($urandom_range(4) != 0) s.ra[1:0] = 2'b00;
      s.sj   = ($urandom_range(99) < 10);
      s.alvo = 26'($urandom);
      s.br   = ($urandom_range(99) < 20);
      s.off  = 16'($urandom);
      passo(s, "rand");
    end

    // Asynchronous reset while in ESPERA
    passo(est(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 16'h0), "pre_exc");
    passo(est(0, 1, 0, 0, 32'h0, 0, 26'h0, 0, 16'h0), "pre_stall");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    modelo_reset();
    #1;
    empilha("reset_async");
    -> amostra;
    @(posedge clk);
    #1;
    empilha("reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) passo(nada, "post_reset");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && fila.size() > 0; i++) @(negedge clk);
    #1;
    if (fila.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", fila.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
